fp_multiplier_param: RTL and testbench

FP_MULTIPLIER_PARAM -- requirements
Module: fp_multiplier_param

---
 rtl/fp_multiplier_param.sv | 193 +++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_param.sv
// Iterative floating-point multiplier: shift-and-add significand product, one-cycle
// normalise, round-to-nearest-even, with valid/ready handshakes on input and output.
module fp_multiplier_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] inputM,
  input  logic [EXP_W+MAN_W:0] inputQ,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic                 of,
  output logic                 uf
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int EW     = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W);

  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_e;
  typedef enum logic [1:0] {SP_NONE, SP_ZERO, SP_INF} special_e;

  state_e               state_q, state_d;
  special_e             special_q, special_d;
  logic                 live_q;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PROD_W-1:0]    prod_q, prod_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic [W-1:0]         out_q, out_d;
  logic                 of_q, of_d, uf_q, uf_d;

  logic [EXP_W-1:0]     in_exp_m, in_exp_q;
  logic                 in_any_inf, in_any_zero;
  logic                 res_sign;
  logic [SIG_W-1:0]     sig_a;
  logic [SIG_W:0]       mul_sum;
  logic signed [EW-1:0] exp_sum;
  logic                 lsb, guard, sticky, round_up;
  logic [SIG_W:0]       sig_rnd;
  logic [MAN_W-1:0]     mant_rnd;
  logic signed [EW-1:0] exp_rnd;
  logic [W-1:0]         inf_word, zero_word;

  assign in_exp_m    = inputM[W-2:MAN_W];
  assign in_exp_q    = inputQ[W-2:MAN_W];
  assign in_any_inf  = (&in_exp_m) | (&in_exp_q);
  assign in_any_zero = (~|in_exp_m) | (~|in_exp_q);

  assign res_sign  = a_q[W-1] ^ b_q[W-1];
  assign inf_word  = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_word = {res_sign, {(W-1){1'b0}}};

  // The low half of prod_q starts as B's significand and shifts out one multiplier
  // bit per cycle while the partial sum enters from the top.
  assign sig_a   = {1'b1, a_q[MAN_W-1:0]};
  assign mul_sum = {1'b0, prod_q[PROD_W-1:SIG_W]} + (prod_q[0] ? {1'b0, sig_a} : '0);

  assign exp_sum = $signed({2'b00, a_q[W-2:MAN_W]}) + $signed({2'b00, b_q[W-2:MAN_W]}) - BIAS;

  // After NORM the leading one sits at bit 2*MAN_W.
  assign lsb      = prod_q[MAN_W];
  assign guard    = prod_q[MAN_W-1];
  assign sticky   = |prod_q[MAN_W-2:0];
  assign round_up = guard & (sticky | lsb);
  assign sig_rnd  = {1'b0, 1'b1, prod_q[2*MAN_W-1:MAN_W]} + (SIG_W+1)'(round_up);
  assign mant_rnd = sig_rnd[SIG_W] ? sig_rnd[MAN_W:1] : sig_rnd[MAN_W-1:0];
  assign exp_rnd  = exp_q + $signed(EW'(sig_rnd[SIG_W]));

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    special_d = special_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    exp_d     = exp_q;
    out_d     = out_q;
    of_d      = of_q;
    uf_d      = uf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d    = inputM;
          b_d    = inputQ;
          cnt_d  = '0;
          prod_d = {{SIG_W{1'b0}}, 1'b1, inputQ[MAN_W-1:0]};
          if (in_any_inf) begin
            special_d = SP_INF;
            state_d   = ROUND;
          end else if (in_any_zero) begin
            special_d = SP_ZERO;
            state_d   = ROUND;
          end else begin
            special_d = SP_NONE;
            state_d   = MUL;
          end
        end
      end
      MUL: begin
        prod_d = {mul_sum, prod_q[SIG_W-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAN_W)) state_d = NORM;
      end
      NORM: begin
        exp_d = exp_sum;
        if (prod_q[PROD_W-1]) begin
          // The bit shifted out is folded into the lowest bit so sticky still sees it.
          prod_d = {1'b0, prod_q[PROD_W-1:2], prod_q[1] | prod_q[0]};
          exp_d  = exp_sum + EXP_ONE;
        end
        state_d = ROUND;
      end
      ROUND: begin
        of_d = 1'b0;
        uf_d = 1'b0;
        unique case (special_q)
          SP_INF: begin
            out_d = inf_word;
            of_d  = 1'b1;
          end
          SP_ZERO: out_d = zero_word;
          default: begin
            if (exp_rnd >= EXP_MAX) begin
              out_d = inf_word;
              of_d  = 1'b1;
            end else if (exp_rnd < EXP_ONE) begin
              out_d = zero_word;
              uf_d  = 1'b1;
            end else begin
              out_d = {res_sign, exp_rnd[EXP_W-1:0], mant_rnd};
            end
          end
        endcase
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      special_q <= SP_NONE;
      live_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      prod_q    <= '0;
      exp_q     <= '0;
      out_q     <= '0;
      of_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      special_q <= special_d;
      live_q    <= 1'b1;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      exp_q     <= exp_d;
      out_q     <= out_d;
      of_q      <= of_d;
      uf_q      <= uf_d;
    end
  end

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = live_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign of        = of_q;
  assign uf        = uf_q;

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Bench for fp_multiplier_param: a default-format and a 5/10 instance, driven with
// directed and random operands, checked by a scoreboard against an arithmetic model.
module tb_fp_multiplier_param;

  localparam int W0 = 32;
  localparam int W1 = 16;

  typedef struct {
    logic [63:0] word;
    logic        of;
    logic        uf;
    int          lat;
    int          acc_cyc;
  } item_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid[2];
  logic          in_ready[2];
  logic          out_valid[2];
  logic          out_ready[2];
  logic          of_v[2];
  logic          uf_v[2];
  logic [W0-1:0] opa0, opb0, res0;
  logic [W1-1:0] opa1, opb1, res1;

  item_t sb0[$];
  item_t sb1[$];
  item_t it_m;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        seen[2];
  logic [63:0] held[2];
  int          first_cyc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fp_multiplier_param #(.EXP_W(8), .MAN_W(23)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .inputM(opa0), .inputQ(opb0),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out(res0), .of(of_v[0]), .uf(uf_v[0])
  );

  fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .inputM(opa1), .inputQ(opb1),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out(res1), .of(of_v[1]), .uf(uf_v[1])
  );

  function automatic int ew_of(int k);
    return (k == 0) ? 8 : 5;
  endfunction

  function automatic int mw_of(int k);
    return (k == 0) ? 23 : 10;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_field(int ew, int mw, logic [63:0] v);
    return int'((v >> mw) & ((64'd1 << ew) - 64'd1));
  endfunction

  // Reference: exact integer product of the significands, rounded by comparing the
  // discarded remainder against one half ulp.
  function automatic logic [65:0] ref_mul(int ew, int mw, logic [63:0] a, logic [63:0] b);
    logic [127:0] ma, mb, p, q, rem, half;
    logic [63:0]  word;
    logic         s, o, u;
    int           ea, eb, e, emax, bias, sh;
    ea   = exp_field(ew, mw, a);
    eb   = exp_field(ew, mw, b);
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    s    = a[ew+mw] ^ b[ew+mw];
    o    = 1'b0;
    u    = 1'b0;
    word = 64'(s) << (ew + mw);
    if (ea == emax || eb == emax) begin
      o    = 1'b1;
      word = word | (64'(emax) << mw);
    end else if (ea != 0 && eb != 0) begin
      ma = 128'(a & ((64'd1 << mw) - 64'd1)) | (128'd1 << mw);
      mb = 128'(b & ((64'd1 << mw) - 64'd1)) | (128'd1 << mw);
      p  = ma * mb;
      e  = ea + eb - bias;
      if ((p >> (2 * mw + 1)) != 0) begin
        sh = mw + 1;
        e++;
      end else begin
        sh = mw;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 128'd1;
      if (q == (128'd1 << (mw + 1))) begin
        q = q >> 1;
        e++;
      end
      if (e >= emax) begin
        o    = 1'b1;
        word = word | (64'(emax) << mw);
      end else if (e <= 0) begin
        u = 1'b1;
      end else begin
        word = word | (64'(e) << mw) | (q[63:0] - (64'd1 << mw));
      end
    end
    return {o, u, word};
  endfunction

  function automatic logic [63:0] rand_op(int ew, int mw);
    int          bias, spread, e, r;
    logic [63:0] m;
    bias   = (1 << (ew - 1)) - 1;
    spread = bias / 2;
    r      = int'($urandom_range(0, 9));
    if (r == 0)      e = 0;
    else if (r == 1) e = (1 << ew) - 1;
    else if (r <= 3) e = int'($urandom_range(0, (1 << ew) - 1));
    else             e = bias - spread + int'($urandom_range(0, 2 * spread));
    m = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    if ($urandom_range(0, 7) == 0) m = '0;
    if ($urandom_range(0, 7) == 0) m = (64'd1 << mw) - 64'd1;
    return (64'($urandom_range(0, 1)) << (ew + mw)) | (64'(e) << mw) | m;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic send(input int k, input logic [63:0] a, input logic [63:0] b);
    item_t       it;
    logic [65:0] r;
    int          ew, mw, ea, eb, emax, g;
    ew = ew_of(k);
    mw = mw_of(k);
    if (k == 0) begin opa0 = a[W0-1:0]; opb0 = b[W0-1:0]; end
    else        begin opa1 = a[W1-1:0]; opb1 = b[W1-1:0]; end
    in_valid[k] = 1'b1;
    g = 0;
    while (!in_ready[k] && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: dut%0d in_ready stayed 0, expected 1", k);
      in_valid[k] = 1'b0;
      return;
    end
    r    = ref_mul(ew, mw, a, b);
    ea   = exp_field(ew, mw, a);
    eb   = exp_field(ew, mw, b);
    emax = (1 << ew) - 1;
    it.word    = r[63:0];
    it.of      = r[65];
    it.uf      = r[64];
    it.lat     = (ea == 0 || eb == 0 || ea == emax || eb == emax) ? 2 : mw + 4;
    it.acc_cyc = cyc + 1;
    if (k == 0) sb0.push_back(it);
    else        sb1.push_back(it);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    // Operands change after acceptance; the result must not follow them.
    if (k == 0) begin opa0 = $urandom; opb0 = $urandom; end
    else        begin opa1 = 16'($urandom); opb1 = 16'($urandom); end
    @(negedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", sb0.size(), sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  // Monitor: checks hold-stability while out_valid waits, and compares each
  // transferred result with the oldest scoreboard entry for that instance.
  always @(negedge clk) begin
    if (!reset) begin
      seen[0] = 1'b0;
      seen[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [63:0] rv;
        logic        have;
        rv = (k == 0) ? 64'(res0) : 64'(res1);
        if (out_valid[k]) begin
          if (!seen[k]) begin
            seen[k]      = 1'b1;
            held[k]      = rv;
            first_cyc[k] = cyc;
          end else begin
            check("hold_out", rv, held[k]);
          end
          check("in_ready_busy", 64'(in_ready[k]), 64'd0);
          if (out_ready[k]) begin
            have = (k == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
            if (!have) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_out: dut%0d out=%h with no pending operation", k, rv);
            end else begin
              it_m = (k == 0) ? sb0.pop_front() : sb1.pop_front();
              check("result", rv, it_m.word);
              check("of", 64'(of_v[k]), 64'(it_m.of));
              check("uf", 64'(uf_v[k]), 64'(it_m.uf));
              check("latency", 64'(first_cyc[k] - it_m.acc_cyc + 1), 64'(it_m.lat));
            end
            seen[k] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  initial begin
    int   g;
    logic bad;
    reset        = 1'b0;
    in_valid[0]  = 1'b0;
    in_valid[1]  = 1'b0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", 64'(out_valid[k]), 64'd0);
      check("rst_in_ready", 64'(in_ready[k]), 64'd0);
      check("rst_of", 64'(of_v[k]), 64'd0);
      check("rst_uf", 64'(uf_v[k]), 64'd0);
    end
    check("rst_out0", 64'(res0), 64'd0);
    check("rst_out1", 64'(res1), 64'd0);

    reset = 1'b1;
    check("ready_before_edge", 64'(in_ready[0]), 64'd0);
    @(posedge clk);
    #1;
    check("ready_first_edge", 64'(in_ready[0]), 64'd1);
    @(negedge clk);

    send(0, 64'h40000000, 64'h40E00000);
    send(0, 64'hC0000000, 64'hC1200000);
    send(0, 64'h3F800001, 64'h3F800001);
    send(0, 64'h43D70000, 64'h00000000);
    send(0, 64'h7F800000, 64'hBF800000);
    send(0, 64'hFF2A8000, 64'hBFD53800);
    send(0, 64'h00800000, 64'h00800000);
    send(0, 64'h00000000, 64'hFF800000);
    send(0, 64'h3FC00000, 64'h3FC00000);

    send(1, 64'h4000, 64'h4200);
    send(1, 64'h3C00, 64'hBC00);
    send(1, 64'h7C00, 64'h0000);
    send(1, 64'h0400, 64'h0400);
    send(1, 64'h7BFF, 64'h7BFF);
    drain();

    out_ready[0] = 1'b0;
    send(0, 64'h40000000, 64'h40E00000);
    g = 0;
    while (!out_valid[0] && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("hold_reached", 64'(out_valid[0]), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid[0]), 64'd1);
      check("hold_value", 64'(res0), 64'h41600000);
    end
    out_ready[0] = 1'b1;
    drain();

    send(0, 64'h40400000, 64'h40400000);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    sb0.delete();
    #1;
    check("mid_reset_valid", 64'(out_valid[0]), 64'd0);
    check("mid_reset_ready", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0]) bad = 1'b1;
    end
    check("no_valid_after_reset", 64'(bad), 64'd0);
    send(0, 64'h3F800001, 64'h3F800001);
    drain();

    for (int i = 0; i < 150; i++) send(0, rand_op(8, 23), rand_op(8, 23));
    for (int i = 0; i < 80; i++) send(1, rand_op(5, 10), rand_op(5, 10));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
